// File: rtl/rgb_led_pwm_seq_pkg.sv
// rgb_led_pwm_seq_pkg: shared mode and breathe-FSM encodings for the RGB LED stage.
package rgb_led_pwm_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISE    = 3'd1,
        S_HOLD_HI = 3'd2,
        S_FALL    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_e;

endpackage

// File: rtl/led_step_timer.sv
// led_step_timer: fade-step prescaler; tick is high for one clk every DIV clks, held at 0 while clr.
module led_step_timer #(
    parameter int DIV = 78125
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = ~clr & (cnt_q == W'(DIV - 1));

    always_comb begin
        cnt_d = (clr | tick) ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rgb_led_pwm_seq.sv
// rgb_led_pwm_seq: drives the RGB LED pads in off/solid/blink/breathe modes using a
// free-running PWM counter, period-aligned mode capture and a breathe fade FSM.
module rgb_led_pwm_seq
    import rgb_led_pwm_seq_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 78125,
    parameter int HOLD_STEPS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [2:0]          colour,
    input  logic                blink_in,
    output logic                redled,
    output logic                greenled,
    output logic                blueled,
    output logic [PWM_BITS-1:0] level
);

    localparam int HW = $clog2(HOLD_STEPS + 1);
    localparam logic [PWM_BITS-1:0] MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);
    localparam logic [HW-1:0]       HEND = HW'(HOLD_STEPS - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [2:0]          colour_q, colour_d;
    logic [2:0]          pad_q, pad_d;
    mode_e               mode_q, mode_d;
    state_e              state_q, state_d;
    logic                en_q;
    logic                step_tick, cap, chg, on;

    led_step_timer #(.DIV(STEP_DIV)) u_step (
        .clk  (clk),
        .rst  (rst),
        .clr  (~en),
        .tick (step_tick)
    );

    // Requests are taken only at a PWM period boundary, or on the first clk of a fresh enable.
    assign cap = en & (~en_q | (pwm_cnt_q == MAX));
    assign chg = cap & (mode_e'(mode) != mode_q);
    assign on  = (level_q == MAX) | (pwm_cnt_q < level_q);

    always_comb begin
        pwm_cnt_d  = en ? pwm_cnt_q + ONE : '0;
        mode_d     = cap ? mode_e'(mode) : mode_q;
        colour_d   = cap ? colour : colour_q;
        pad_d      = en ? (colour_q & {3{on}}) : 3'b000;
        state_d    = state_q;
        level_d    = level_q;
        hold_cnt_d = hold_cnt_q;
        if (!en || chg) begin
            state_d    = S_IDLE;
            level_d    = '0;
            hold_cnt_d = '0;
        end else if (mode_q != MODE_BREATHE) begin
            state_d    = S_IDLE;
            hold_cnt_d = '0;
            level_d    = (mode_q == MODE_SOLID) ? MAX :
                         (mode_q == MODE_BLINK && blink_in) ? MAX : '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_RISE;
                    level_d = '0;
                end
                S_RISE: if (step_tick) begin
                    level_d    = (level_q >= MAX - ONE) ? MAX : level_q + ONE;
                    state_d    = (level_q >= MAX - ONE) ? S_HOLD_HI : S_RISE;
                    hold_cnt_d = '0;
                end
                S_HOLD_HI: if (step_tick) begin
                    state_d    = (hold_cnt_q == HEND) ? S_FALL : S_HOLD_HI;
                    hold_cnt_d = (hold_cnt_q == HEND) ? '0 : hold_cnt_q + HW'(1);
                end
                S_FALL: if (step_tick) begin
                    level_d    = (level_q <= ONE) ? '0 : level_q - ONE;
                    state_d    = (level_q <= ONE) ? S_HOLD_LO : S_FALL;
                    hold_cnt_d = '0;
                end
                S_HOLD_LO: if (step_tick) begin
                    state_d    = (hold_cnt_q == HEND) ? S_RISE : S_HOLD_LO;
                    hold_cnt_d = (hold_cnt_q == HEND) ? '0 : hold_cnt_q + HW'(1);
                end
                default: begin
                    state_d = S_IDLE;
                    level_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q  <= '0;
            level_q    <= '0;
            hold_cnt_q <= '0;
            colour_q   <= '0;
            pad_q      <= '0;
            mode_q     <= MODE_OFF;
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            level_q    <= level_d;
            hold_cnt_q <= hold_cnt_d;
            colour_q   <= colour_d;
            pad_q      <= pad_d;
            mode_q     <= mode_d;
            state_q    <= state_d;
            en_q       <= en;
        end
    end

    assign redled   = pad_q[2];
    assign greenled = pad_q[1];
    assign blueled  = pad_q[0];
    assign level    = level_q;

endmodule
